// File: rtl/bit_sync_pkg.sv
// Shared constants for the multi-flop level synchronizer.
package bit_sync_pkg;
    localparam int DEFAULT_NUM_STAGES = 2;
    localparam int DEFAULT_BUS_WIDTH  = 1;
    localparam int MIN_SYNC_STAGES    = 2;
endpackage

// File: rtl/sync_chain_1b.sv
// Single-bit synchronizer chain: NUM_STAGES back-to-back flops, no logic between them.
module sync_chain_1b
    import bit_sync_pkg::*;
#(
    parameter int NUM_STAGES = DEFAULT_NUM_STAGES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_sync
);

    if (NUM_STAGES < MIN_SYNC_STAGES) begin : g_bad_stages
        $error("sync_chain_1b: NUM_STAGES must be >= %0d", MIN_SYNC_STAGES);
    end

    // Attribute keeps the flops intact and co-located for MTBF.
    (* ASYNC_REG = "TRUE" *) logic [NUM_STAGES-1:0] r_stage;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_stage <= '0;
        else       r_stage <= {r_stage[NUM_STAGES-2:0], i_async};
    end

    assign o_sync = r_stage[NUM_STAGES-1];

endmodule

// File: rtl/bit_sync.sv
// Level synchronizer for a quasi-static bus; each bit gets its own independent chain.
module bit_sync
    import bit_sync_pkg::*;
#(
    parameter int NUM_STAGES = DEFAULT_NUM_STAGES,
    parameter int BUS_WIDTH  = DEFAULT_BUS_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] ASYNC,
    output logic [BUS_WIDTH-1:0] SYNC
);

    if (NUM_STAGES < MIN_SYNC_STAGES) begin : g_bad_stages
        $error("bit_sync: NUM_STAGES must be >= %0d", MIN_SYNC_STAGES);
    end
    if (BUS_WIDTH < 1) begin : g_bad_width
        $error("bit_sync: BUS_WIDTH must be >= 1");
    end

    for (genvar i = 0; i < BUS_WIDTH; i++) begin : g_bit
        sync_chain_1b #(.NUM_STAGES(NUM_STAGES)) u_chain (
            .i_clk   (CLK),
            .i_rst   (RST),
            .i_async (ASYNC[i]),
            .o_sync  (SYNC[i])
        );
    end

endmodule

// File: tb/tb_bit_sync.sv
// Bench for bit_sync: default instance (1 bit, 2 stages) and a 4-bit, 3-stage instance.
module tb_bit_sync;
    logic       clk = 1'b0;
    logic       rst;
    logic       async_a;
    logic [3:0] async_b;
    logic       sync_a;
    logic [3:0] sync_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bit_sync u_dut_a (
        .CLK   (clk),
        .RST   (rst),
        .ASYNC (async_a),
        .SYNC  (sync_a)
    );

    bit_sync #(.NUM_STAGES(3), .BUS_WIDTH(4)) u_dut_b (
        .CLK   (clk),
        .RST   (rst),
        .ASYNC (async_b),
        .SYNC  (sync_b)
    );

    typedef struct {
        string      name;
        logic       rst;
        logic       a;
        logic [3:0] b;
        int         edges;
        logic       exp_a;
        logic [3:0] exp_b;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Reference: SYNC is the input sampled NUM_STAGES rising edges ago,
    // or 0 if fewer edges than that have occurred since reset release.
    logic       hist_a[$];
    logic [3:0] hist_b[$];

    function automatic logic model_a();
        return (hist_a.size() >= 2) ? hist_a[hist_a.size()-2] : 1'b0;
    endfunction

    function automatic logic [3:0] model_b();
        return (hist_b.size() >= 3) ? hist_b[hist_b.size()-3] : 4'b0;
    endfunction

    initial begin
        vecs[0]  = '{"rst_immediate",  1, 1, 4'hF,    0, 0, 4'h0};
        vecs[1]  = '{"rst_held",       1, 1, 4'hF,    1, 0, 4'h0};
        vecs[2]  = '{"release_zero",   0, 0, 4'h0,    2, 0, 4'h0};
        vecs[3]  = '{"rise_1edge",     0, 1, 4'b1010, 1, 0, 4'h0};
        vecs[4]  = '{"rise_2edge",     0, 1, 4'b1010, 1, 1, 4'h0};
        vecs[5]  = '{"rise_3edge",     0, 1, 4'b1010, 1, 1, 4'b1010};
        vecs[6]  = '{"fall_1edge",     0, 0, 4'b1010, 1, 1, 4'b1010};
        vecs[7]  = '{"fall_2edge",     0, 0, 4'b1010, 1, 0, 4'b1010};
        vecs[8]  = '{"rerise_2edge",   0, 1, 4'b1010, 2, 1, 4'b1010};
        vecs[9]  = '{"midop_rst",      1, 1, 4'b1010, 0, 0, 4'h0};
        vecs[10] = '{"midop_rst_held", 1, 1, 4'b1010, 1, 0, 4'h0};
        vecs[11] = '{"refill_1edge",   0, 1, 4'b1010, 1, 0, 4'h0};
        vecs[12] = '{"refill_2edge",   0, 1, 4'b1010, 1, 1, 4'h0};
        vecs[13] = '{"refill_3edge",   0, 1, 4'b1010, 1, 1, 4'b1010};

        rst = 1'b0; async_a = 1'b0; async_b = 4'h0;

        // Directed vectors: inputs change between edges (on the falling edge).
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            rst = vecs[i].rst; async_a = vecs[i].a; async_b = vecs[i].b;
            repeat (vecs[i].edges) @(posedge clk);
            #1;
            check({vecs[i].name, "_a"}, {3'b0, sync_a}, {3'b0, vecs[i].exp_a});
            check({vecs[i].name, "_b"}, sync_b, vecs[i].exp_b);
        end

        // Randomized levels with occasional mid-operation resets against the model.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        hist_a.delete(); hist_b.delete();
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            rst     = ($urandom_range(0, 39) == 0);
            async_a = 1'($urandom);
            async_b = 4'($urandom);
            if (rst) begin
                #1;
                check("rnd_rst_async_a", {3'b0, sync_a}, 4'h0);
                check("rnd_rst_async_b", sync_b, 4'h0);
            end
            @(posedge clk);
            if (rst) begin
                hist_a.delete(); hist_b.delete();
            end else begin
                hist_a.push_back(async_a);
                hist_b.push_back(async_b);
                if (hist_a.size() > 4) void'(hist_a.pop_front());
                if (hist_b.size() > 4) void'(hist_b.pop_front());
            end
            #1;
            check("rnd_a", {3'b0, sync_a}, {3'b0, model_a()});
            check("rnd_b", sync_b, model_b());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
